tlb_op_ctrl: RTL and testbench

Sequencer for the MIPS TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) against the shared `tlb` array. Sits between the CP0/execute stage and `tlb`. Accepts one operation at a time over a valid/ready handshake and drives the TLB write strobe and index. Captures probe and read results, owns the CP0 Random register, and holds off inst/data lookups while a write settles.

---
 rtl/tlb_op_ctrl_pkg.sv | 33 +++
 rtl/tlb_random.sv | 32 +++
 rtl/tlb_op_ctrl.sv | 157 +++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB geometry, maintenance-op encodings and sequencer state encodings
// for the TLB maintenance sequencer.
package tlb_op_ctrl_pkg;

    localparam int TLB_ENTRIES = 32;
    localparam int TLB_IDXBITS = 5;

    // EntryHi / EntryLo field positions, kept next to the TLB geometry.
    localparam int ENTRYHI_VPN2_LSB = 13;
    localparam int ENTRYHI_ASID_MSB = 7;
    localparam int ENTRYLO_PFN_LSB  = 6;

    typedef enum logic [1:0] {
        TLBOP_P  = 2'b00,
        TLBOP_R  = 2'b01,
        TLBOP_WI = 2'b10,
        TLBOP_WR = 2'b11
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROBE  = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } tlb_state_e;

    function automatic logic op_is_write(input tlb_op_e op);
        return op == TLBOP_WI || op == TLBOP_WR;
    endfunction

endpackage

// File: rtl/tlb_random.sv
// CP0 Random register: counts down from ENTRIES-1 and wraps back at Wired or 0.
module tlb_random
    import tlb_op_ctrl_pkg::*;
#(
    parameter int ENTRIES = TLB_ENTRIES,
    parameter int IDXBITS = TLB_IDXBITS
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [IDXBITS-1:0] wired,
    input  logic               wired_we,
    input  logic               step,
    output logic [IDXBITS-1:0] random
);

    localparam logic [IDXBITS-1:0] TOP = IDXBITS'(ENTRIES - 1);

    // A Wired value of ENTRIES-1 makes every step wrap, so Random parks at TOP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random <= TOP;
        end else if (wired_we) begin
            random <= TOP;
        end else if (step) begin
            if (random == wired || random == '0)
                random <= TOP;
            else
                random <= random - IDXBITS'(1);
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the shared TLB array, captures the
// results for CP0 and stalls lookups while a write settles.
//
// state  | meaning
// IDLE   | ready for a new operation
// PROBE  | capture probe result
// READ   | index driven, capture read data
// WRITE  | one-cycle write strobe
// SETTLE | written entry propagating, lookups still held
// DONE   | completion pulse with CP0 write enables
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int ENTRIES = TLB_ENTRIES,
    parameter int IDXBITS = TLB_IDXBITS
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op,
    input  logic [31:0]        cp0_index,
    input  logic [IDXBITS-1:0] cp0_wired,
    input  logic               wired_we,
    input  logic               random_step,
    output logic [IDXBITS-1:0] random,
    output logic               tlb_write,
    output logic [IDXBITS-1:0] tlb_idx,
    input  logic [31:0]        tlb_probe_index,
    input  logic [31:0]        tlb_read_hi,
    input  logic [31:0]        tlb_read_lo0,
    input  logic [31:0]        tlb_read_lo1,
    input  logic [11:0]        tlb_read_mask,
    output logic               done,
    output logic               res_we_index,
    output logic               res_we_entry,
    output logic [31:0]        res_index,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo0,
    output logic [31:0]        res_lo1,
    output logic [11:0]        res_mask,
    output logic               lookup_hold
);

    tlb_state_e         state;
    tlb_op_e            op_q;
    logic [IDXBITS-1:0] idx_q;
    tlb_op_e            op_in;

    logic unused_index_bits;
    assign unused_index_bits = ^cp0_index[31:IDXBITS];

    assign op_in   = tlb_op_e'(op);
    assign tlb_idx = idx_q;

    tlb_random #(
        .ENTRIES (ENTRIES),
        .IDXBITS (IDXBITS)
    ) u_random (
        .clk      (clk),
        .resetn   (resetn),
        .wired    (cp0_wired),
        .wired_we (wired_we),
        .step     (random_step),
        .random   (random)
    );

    // Outputs are registered alongside the state they decode, so they change
    // only at state transitions and clear asynchronously with reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            op_q         <= TLBOP_P;
            idx_q        <= '0;
            op_ready     <= 1'b1;
            tlb_write    <= 1'b0;
            lookup_hold  <= 1'b0;
            done         <= 1'b0;
            res_we_index <= 1'b0;
            res_we_entry <= 1'b0;
            res_index    <= '0;
            res_hi       <= '0;
            res_lo0      <= '0;
            res_lo1      <= '0;
            res_mask     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_q     <= op_in;
                        op_ready <= 1'b0;
                        case (op_in)
                            TLBOP_P: state <= ST_PROBE;
                            TLBOP_R: begin
                                state <= ST_READ;
                                idx_q <= cp0_index[IDXBITS-1:0];
                            end
                            TLBOP_WI: begin
                                state <= ST_WRITE;
                                idx_q <= cp0_index[IDXBITS-1:0];
                            end
                            TLBOP_WR: begin
                                state <= ST_WRITE;
                                idx_q <= random;
                            end
                        endcase
                        if (op_is_write(op_in)) begin
                            tlb_write   <= 1'b1;
                            lookup_hold <= 1'b1;
                        end
                    end
                end
                ST_PROBE: begin
                    res_index    <= tlb_probe_index;
                    res_we_index <= (op_q == TLBOP_P);
                    done         <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_READ: begin
                    res_hi       <= tlb_read_hi;
                    res_lo0      <= tlb_read_lo0;
                    res_lo1      <= tlb_read_lo1;
                    res_mask     <= tlb_read_mask;
                    res_we_entry <= (op_q == TLBOP_R);
                    done         <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_WRITE: begin
                    tlb_write <= 1'b0;
                    state     <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    lookup_hold <= 1'b0;
                    done        <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    done         <= 1'b0;
                    res_we_index <= 1'b0;
                    res_we_entry <= 1'b0;
                    op_ready     <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    op_ready     <= 1'b1;
                    tlb_write    <= 1'b0;
                    lookup_hold  <= 1'b0;
                    done         <= 1'b0;
                    res_we_index <= 1'b0;
                    res_we_entry <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: directed latency cases plus a random
// op stream checked against a cycle-count reference and a Random model.
module tb_tlb_op_ctrl;

    localparam int ENTRIES = 32;
    localparam int IDXBITS = 5;
    localparam logic [IDXBITS-1:0] TOP = 5'd31;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] cp0_index = '0;
    logic [4:0]  cp0_wired = '0;
    logic        wired_we = 1'b0;
    logic        random_step = 1'b0;
    logic [4:0]  random;
    logic        tlb_write;
    logic [4:0]  tlb_idx;
    logic [31:0] tlb_probe_index = '0;
    logic [31:0] tlb_read_hi = '0;
    logic [31:0] tlb_read_lo0 = '0;
    logic [31:0] tlb_read_lo1 = '0;
    logic [11:0] tlb_read_mask = '0;
    logic        done;
    logic        res_we_index;
    logic        res_we_entry;
    logic [31:0] res_index;
    logic [31:0] res_hi;
    logic [31:0] res_lo0;
    logic [31:0] res_lo1;
    logic [11:0] res_mask;
    logic        lookup_hold;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] rnd_m;
    logic [4:0] last_idx;

    tlb_op_ctrl #(.ENTRIES(ENTRIES), .IDXBITS(IDXBITS)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op              (op),
        .cp0_index       (cp0_index),
        .cp0_wired       (cp0_wired),
        .wired_we        (wired_we),
        .random_step     (random_step),
        .random          (random),
        .tlb_write       (tlb_write),
        .tlb_idx         (tlb_idx),
        .tlb_probe_index (tlb_probe_index),
        .tlb_read_hi     (tlb_read_hi),
        .tlb_read_lo0    (tlb_read_lo0),
        .tlb_read_lo1    (tlb_read_lo1),
        .tlb_read_mask   (tlb_read_mask),
        .done            (done),
        .res_we_index    (res_we_index),
        .res_we_entry    (res_we_entry),
        .res_index       (res_index),
        .res_hi          (res_hi),
        .res_lo0         (res_lo0),
        .res_lo1         (res_lo1),
        .res_mask        (res_mask),
        .lookup_hold     (lookup_hold)
    );

    always #5 clk = ~clk;

    // Reference Random: a plain down-counter that restarts at the top after
    // reaching Wired or zero; a Wired write always restarts it.
    always @(posedge clk or negedge resetn) begin
        if (!resetn)
            rnd_m <= TOP;
        else if (wired_we)
            rnd_m <= TOP;
        else if (random_step)
            rnd_m <= (rnd_m == 0 || rnd_m == cp0_wired) ? TOP : rnd_m - 5'd1;
    end

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        last_idx = '0;
        n_checks++;
        if ({op_ready, done, res_we_index, res_we_entry, tlb_write, lookup_hold} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 100000",
                     {op_ready, done, res_we_index, res_we_entry, tlb_write, lookup_hold});
        end
        n_checks++;
        if ({res_index, res_hi, res_lo0, res_lo1, res_mask} !== '0 || tlb_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_res: res/idx not zero, tlb_idx=%0d", tlb_idx);
        end
        n_checks++;
        if (random !== TOP) begin
            n_fail++;
            $display("FAIL reset_random: got %0d want %0d", random, TOP);
        end
    endtask

    task automatic test_probe;
        bit saw_write = 0;
        tlb_probe_index = 32'h8000_0000;
        op = 2'b00;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        saw_write |= tlb_write;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL probe_c1_done: got %b want 0", done);
        end
        @(negedge clk);
        saw_write |= tlb_write;
        n_checks++;
        if (done !== 1'b1 || res_we_index !== 1'b1 || res_we_entry !== 1'b0 || res_index !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL probe_c2: done=%b we_index=%b we_entry=%b res_index=%h want 1 1 0 80000000",
                     done, res_we_index, res_we_entry, res_index);
        end
        @(negedge clk);
        saw_write |= tlb_write;
        n_checks++;
        if (saw_write || done !== 1'b0 || op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL probe_after: write_seen=%b done=%b ready=%b want 0 0 1", saw_write, done, op_ready);
        end
    endtask

    task automatic test_read;
        cp0_index = 32'd5;
        tlb_read_hi = 32'h1234_5000;
        tlb_read_lo0 = 32'h0000_0abc;
        tlb_read_lo1 = 32'h0000_0def;
        tlb_read_mask = 12'h003;
        op = 2'b01;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        last_idx = 5'd5;
        n_checks++;
        if (tlb_idx !== 5'd5 || tlb_write !== 1'b0) begin
            n_fail++;
            $display("FAIL read_c1: tlb_idx=%0d write=%b want 5 0", tlb_idx, tlb_write);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || res_we_entry !== 1'b1 || res_we_index !== 1'b0 || res_hi !== 32'h1234_5000 ||
            res_lo0 !== 32'h0000_0abc || res_lo1 !== 32'h0000_0def || res_mask !== 12'h003) begin
            n_fail++;
            $display("FAIL read_c2: done=%b we_entry=%b we_index=%b hi=%h lo0=%h lo1=%h mask=%h",
                     done, res_we_entry, res_we_index, res_hi, res_lo0, res_lo1, res_mask);
        end
        n_checks++;
        if (res_index !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL read_keeps_index: got %h want 80000000", res_index);
        end
        @(negedge clk);
    endtask

    task automatic test_write_wi;
        cp0_index = 32'hFFFF_0003;
        op = 2'b10;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        last_idx = 5'd3;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (tlb_write !== (c == 1) || lookup_hold !== (c == 1 || c == 2) || done !== (c == 3) ||
                op_ready !== (c == 4) || tlb_idx !== 5'd3 || res_we_index !== 1'b0 || res_we_entry !== 1'b0) begin
                n_fail++;
                $display("FAIL wi_cycle%0d: write=%b hold=%b done=%b ready=%b idx=%0d weI=%b weE=%b",
                         c, tlb_write, lookup_hold, done, op_ready, tlb_idx, res_we_index, res_we_entry);
            end
            if (c < 4) @(negedge clk);
        end
    endtask

    task automatic test_random_seq;
        cp0_wired = 5'd4;
        wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        n_checks++;
        if (random !== TOP) begin
            n_fail++;
            $display("FAIL rand_start: got %0d want 31", random);
        end
        for (int i = 0; i < 28; i++) begin
            logic [4:0] exp;
            random_step = 1'b1;
            @(negedge clk);
            exp = (i < 27) ? 5'(30 - i) : TOP;
            n_checks++;
            if (random !== exp) begin
                n_fail++;
                $display("FAIL rand_step%0d: got %0d want %0d", i, random, exp);
            end
        end
        random_step = 1'b1;
        repeat (3) @(negedge clk);
        wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        random_step = 1'b0;
        n_checks++;
        if (random !== TOP) begin
            n_fail++;
            $display("FAIL rand_wired_override: got %0d want 31", random);
        end
    endtask

    task automatic test_tlbwr_step;
        random_step = 1'b1;
        repeat (22) @(negedge clk);
        random_step = 1'b0;
        n_checks++;
        if (random !== 5'd9) begin
            n_fail++;
            $display("FAIL wr_setup_random: got %0d want 9", random);
        end
        op = 2'b11;
        op_valid = 1'b1;
        random_step = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        random_step = 1'b0;
        last_idx = 5'd9;
        n_checks++;
        if (tlb_idx !== 5'd9 || tlb_write !== 1'b1 || random !== 5'd8) begin
            n_fail++;
            $display("FAIL wr_step: idx=%0d write=%b random=%0d want 9 1 8", tlb_idx, tlb_write, random);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random_ops;
        cp0_wired = 5'($urandom_range(0, 31));
        wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int o;
            int lat;
            bit is_wr;
            logic [4:0] exp_idx;
            logic [31:0] pidx, hi, lo0, lo1;
            logic [11:0] msk;
            o = $urandom_range(0, 3);
            is_wr = (o >= 2);
            lat = is_wr ? 3 : 2;
            pidx = $urandom;
            hi = $urandom;
            lo0 = $urandom;
            lo1 = $urandom;
            msk = 12'($urandom);
            cp0_index = $urandom;
            tlb_probe_index = pidx;
            tlb_read_hi = hi;
            tlb_read_lo0 = lo0;
            tlb_read_lo1 = lo1;
            tlb_read_mask = msk;
            n_checks++;
            if (op_ready !== 1'b1 || random !== rnd_m) begin
                n_fail++;
                $display("FAIL rops%0d_accept: ready=%b random=%0d want 1 %0d", n, op_ready, random, rnd_m);
            end
            case (o)
                0: exp_idx = last_idx;
                3: exp_idx = rnd_m;
                default: exp_idx = cp0_index[4:0];
            endcase
            last_idx = exp_idx;
            op = 2'(o);
            op_valid = 1'b1;
            random_step = 1'($urandom);
            for (int c = 1; c <= lat + 1; c++) begin
                @(negedge clk);
                op_valid = 1'b0;
                random_step = 1'($urandom);
                n_checks++;
                if (tlb_write !== (is_wr && c == 1) || lookup_hold !== (is_wr && (c == 1 || c == 2)) ||
                    done !== (c == lat) || tlb_idx !== exp_idx || random !== rnd_m ||
                    op_ready !== (c == lat + 1)) begin
                    n_fail++;
                    $display("FAIL rops%0d_op%0d_c%0d: write=%b hold=%b done=%b idx=%0d/%0d rnd=%0d/%0d ready=%b",
                             n, o, c, tlb_write, lookup_hold, done, tlb_idx, exp_idx, random, rnd_m, op_ready);
                end
                if (c == lat) begin
                    n_checks++;
                    if (res_we_index !== (o == 0) || res_we_entry !== (o == 1) ||
                        (o == 0 && res_index !== pidx) ||
                        (o == 1 && (res_hi !== hi || res_lo0 !== lo0 || res_lo1 !== lo1 || res_mask !== msk))) begin
                        n_fail++;
                        $display("FAIL rops%0d_res op%0d: weI=%b weE=%b idx=%h/%h hi=%h/%h",
                                 n, o, res_we_index, res_we_entry, res_index, pidx, res_hi, hi);
                    end
                end
            end
        end
        random_step = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        cp0_index = 32'd7;
        op = 2'b10;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n_checks++;
        if (tlb_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_pre: write=%b want 1", tlb_write);
        end
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (tlb_write !== 1'b0 || lookup_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_async: write=%b hold=%b want 0 0", tlb_write, lookup_hold);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1 || random !== TOP || done !== 1'b0 || tlb_write !== 1'b0 || tlb_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL rstw_after: ready=%b random=%0d done=%b write=%b idx=%0d want 1 31 0 0 0",
                     op_ready, random, done, tlb_write, tlb_idx);
        end
    endtask

    initial begin
        test_reset();
        test_probe();
        test_read();
        test_write_wi();
        test_random_seq();
        test_tlbwr_step();
        test_random_ops();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
